// File: rtl/sort_ingress_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : sort_ingress_if                                            |
// | Brief    : Per-port push bus and sorter-facing record bus.            |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
`ifndef PORT_NUB_TOTAL
`define PORT_NUB_TOTAL 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

interface sort_ingress_if #(
  parameter int PORT_NUB   = 4,
  parameter int PID_W      = 2,
  parameter int DATA_WIDTH = 8,
  parameter int LVL_W      = 3
);
  localparam int REC_W = 1 + 2*PID_W + DATA_WIDTH;

  logic [PORT_NUB-1:0]            in_valid;
  logic [PORT_NUB-1:0]            in_ready;
  logic [PORT_NUB*PID_W-1:0]      in_dst;
  logic [PORT_NUB*DATA_WIDTH-1:0] in_data;
  logic                           issue_en;
  logic [PORT_NUB*REC_W-1:0]      port_out;
  logic [PORT_NUB*LVL_W-1:0]      fifo_level;

  modport master (
    output in_valid, in_dst, in_data, issue_en,
    input  in_ready, port_out, fifo_level
  );

  modport slave (
    input  in_valid, in_dst, in_data, issue_en,
    output in_ready, port_out, fifo_level
  );
endinterface
`default_nettype wire

// File: rtl/sort_ingress.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : sort_ingress                                               |
// | Brief    : Per-port request FIFOs and collision-free record issue     |
// |            feeding the odd-even merge sort network.                   |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
`ifndef PORT_NUB_TOTAL
`define PORT_NUB_TOTAL 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module sort_ingress #(
  parameter int PORT_NUB   = 4,
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int FIFO_DEPTH = 4,
  parameter int PORT_BASE  = 0
) (
  input wire            clk,
  input wire            rst,
  sort_ingress_if.slave bus
);

  localparam int PID_W  = $clog2(`PORT_NUB_TOTAL);
  localparam int REC_W  = 1 + 2*PID_W + DATA_WIDTH;
  localparam int LVL_W  = $clog2(FIFO_DEPTH+1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int PORT_W = $clog2(PORT_NUB);
  localparam int ENT_W  = PID_W + DATA_WIDTH;
  localparam int NDST   = 1 << PID_W;

  logic [PORT_NUB-1:0]                 ready;
  logic [PORT_NUB-1:0]                 nonempty;
  logic [PORT_NUB-1:0]                 grant;
  logic [PORT_NUB-1:0][PID_W-1:0]      head_dst;
  logic [PORT_NUB-1:0][DATA_WIDTH-1:0] head_data;
  logic [PORT_NUB-1:0][LVL_W-1:0]      level_w;

  logic [PORT_NUB-1:0][REC_W-1:0]      port_out_q, port_out_d;
  logic [PORT_W-1:0]                   rr_ptr_q, rr_ptr_d;

  logic [NDST-1:0]                     dst_taken;
  logic [PORT_W-1:0]                   idx;

  for (genvar k = 0; k < PORT_NUB; k++) begin : g_port
    logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             push;
    logic             pop;
    logic [ENT_W-1:0] head;

    // Ready looks only at the registered level, so a full FIFO refuses
    // input even in a cycle where it is being popped.
    assign ready[k]     = !rst && (level_q != LVL_W'(FIFO_DEPTH));
    assign push         = bus.in_valid[k] && ready[k];
    assign pop          = grant[k];
    assign head         = mem_q[rd_ptr_q];
    assign head_dst[k]  = head[ENT_W-1 -: PID_W];
    assign head_data[k] = head[DATA_WIDTH-1:0];
    assign nonempty[k]  = (level_q != '0);
    assign level_w[k]   = level_q;

    always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      level_d = level_q + LVL_W'(1);
      else if (pop && !push) level_d = level_q - LVL_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        level_q  <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        level_q  <= level_d;
      end
    end

    // Storage is not reset; stale entries are unreachable once level is 0.
    always_ff @(posedge clk) begin
      if (push) begin
        mem_q[wr_ptr_q] <= {bus.in_dst[k*PID_W +: PID_W],
                            bus.in_data[k*DATA_WIDTH +: DATA_WIDTH]};
      end
    end
  end

  always_comb begin
    dst_taken  = '0;
    grant      = '0;
    idx        = '0;
    port_out_d = '0;
    // Scan from rr_ptr; the first port to claim a destination keeps it.
    for (int i = 0; i < PORT_NUB; i++) begin
      idx = rr_ptr_q + PORT_W'(i);
      if (bus.issue_en && nonempty[idx] && !dst_taken[head_dst[idx]]) begin
        grant[idx]               = 1'b1;
        dst_taken[head_dst[idx]] = 1'b1;
      end
    end
    for (int k = 0; k < PORT_NUB; k++) begin
      if (grant[k]) begin
        port_out_d[k] = {1'b1, head_dst[k], PID_W'(PORT_BASE + k), head_data[k]};
      end
    end
    rr_ptr_d = (|grant) ? rr_ptr_q + PORT_W'(1) : rr_ptr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      port_out_q <= '0;
      rr_ptr_q   <= '0;
    end else begin
      port_out_q <= port_out_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign bus.in_ready   = ready;
  assign bus.port_out   = port_out_q;
  assign bus.fifo_level = level_w;

endmodule
`default_nettype wire

// File: tb/tb_sort_ingress.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : tb_sort_ingress                                            |
// | Brief    : Directed vector bench for sort_ingress (4 ports, 8b data). |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
module tb_sort_ingress;

  localparam logic [12:0] Z = 13'd0;

  typedef struct {
    string       nm;
    logic [3:0]  vld;
    logic [7:0]  dst;
    logic [31:0] dat;
    logic        iss;
    logic [51:0] eout;
    logic [11:0] elvl;
    logic [3:0]  erdy;
  } vec_t;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_bad;
  vec_t tv[$];

  sort_ingress_if #(.PORT_NUB(4), .PID_W(2), .DATA_WIDTH(8), .LVL_W(3)) bus ();

  sort_ingress #(
    .PORT_NUB(4), .DATA_WIDTH(8), .FIFO_DEPTH(4), .PORT_BASE(0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [12:0] rec(input int dst, input int src, input int dat);
    logic [1:0] d;
    logic [1:0] s;
    logic [7:0] x;
    d = 2'(dst);
    s = 2'(src);
    x = 8'(dat);
    return {1'b1, d, s, x};
  endfunction

  function automatic logic [11:0] lv(input int l3, input int l2, input int l1, input int l0);
    return {3'(l3), 3'(l2), 3'(l1), 3'(l0)};
  endfunction

  task automatic add(input string nm, input logic [3:0] vld, input logic [7:0] dst,
                     input logic [31:0] dat, input logic iss, input logic [51:0] eout,
                     input logic [11:0] elvl, input logic [3:0] erdy);
    vec_t v;
    v.nm = nm; v.vld = vld; v.dst = dst; v.dat = dat; v.iss = iss;
    v.eout = eout; v.elvl = elvl; v.erdy = erdy;
    tv.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] vld, input logic [7:0] dst,
                       input logic [31:0] dat, input logic iss);
    bus.in_valid = vld;
    bus.in_dst   = dst;
    bus.in_data  = dat;
    bus.issue_en = iss;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_bad = 0;
    rst   = 1'b1;
    drive(4'b0, 8'b0, 32'b0, 1'b0);

    // Vector table: rr_ptr history noted per line as "rr a->b".
    add("idle",        4'b0000, 8'h00, 32'h0, 1'b1, '0, lv(0,0,0,0), 4'hF);
    add("push2",       4'b0100, 8'b00_01_00_00, 32'h00A5_0000, 1'b1, '0, lv(0,1,0,0), 4'hF);
    add("issue2",      4'b0000, 8'h00, 32'h0, 1'b1, {Z, rec(1,2,8'hA5), Z, Z}, lv(0,0,0,0), 4'hF); // rr 0->1
    add("coll_push",   4'b1001, 8'b10_00_00_10, 32'h3300_0011, 1'b0, '0, lv(1,0,0,1), 4'hF);
    add("coll_win3",   4'b0000, 8'h00, 32'h0, 1'b1, {rec(2,3,8'h33), Z, Z, Z}, lv(0,0,0,1), 4'hF); // rr 1->2
    add("coll_late0",  4'b0000, 8'h00, 32'h0, 1'b1, {Z, Z, Z, rec(2,0,8'h11)}, lv(0,0,0,0), 4'hF); // rr 2->3
    add("idle_hold",   4'b0000, 8'h00, 32'h0, 1'b1, '0, lv(0,0,0,0), 4'hF);
    add("fill1_a",     4'b0010, 8'h00, 32'h0000_4000, 1'b0, '0, lv(0,0,1,0), 4'hF);
    add("fill1_b",     4'b0010, 8'h00, 32'h0000_4100, 1'b0, '0, lv(0,0,2,0), 4'hF);
    add("fill1_c",     4'b0010, 8'h00, 32'h0000_4200, 1'b0, '0, lv(0,0,3,0), 4'hF);
    add("fill1_d",     4'b0010, 8'h00, 32'h0000_4300, 1'b0, '0, lv(0,0,4,0), 4'b1101);
    add("full_refuse", 4'b0010, 8'h00, 32'h0000_4400, 1'b0, '0, lv(0,0,4,0), 4'b1101);
    add("full_pop",    4'b0000, 8'h00, 32'h0, 1'b1, {Z, Z, rec(0,1,8'h40), Z}, lv(0,0,3,0), 4'hF); // rr 3->0
    add("bubble_a",    4'b0000, 8'h00, 32'h0, 1'b0, '0, lv(0,0,3,0), 4'hF);
    add("bubble_b",    4'b0000, 8'h00, 32'h0, 1'b0, '0, lv(0,0,3,0), 4'hF);
    add("bubble_c",    4'b0000, 8'h00, 32'h0, 1'b0, '0, lv(0,0,3,0), 4'hF);
    add("drain_41",    4'b0000, 8'h00, 32'h0, 1'b1, {Z, Z, rec(0,1,8'h41), Z}, lv(0,0,2,0), 4'hF); // rr 0->1
    add("drain_42",    4'b0000, 8'h00, 32'h0, 1'b1, {Z, Z, rec(0,1,8'h42), Z}, lv(0,0,1,0), 4'hF); // rr 1->2
    add("drain_43",    4'b0000, 8'h00, 32'h0, 1'b1, {Z, Z, rec(0,1,8'h43), Z}, lv(0,0,0,0), 4'hF); // rr 2->3
    add("no_5th",      4'b0000, 8'h00, 32'h0, 1'b1, '0, lv(0,0,0,0), 4'hF);
    add("par_push",    4'b1111, 8'b00_01_10_11, 32'hC3C2_C1C0, 1'b1, '0, lv(1,1,1,1), 4'hF);
    add("par_issue",   4'b0000, 8'h00, 32'h0, 1'b1,
        {rec(0,3,8'hC3), rec(1,2,8'hC2), rec(2,1,8'hC1), rec(3,0,8'hC0)}, lv(0,0,0,0), 4'hF); // rr 3->0
    add("pp_push",     4'b0001, 8'b00_00_00_01, 32'h0000_00D0, 1'b1, '0, lv(0,0,0,1), 4'hF);
    add("pp_both",     4'b0001, 8'b00_00_00_10, 32'h0000_00D1, 1'b1, {Z, Z, Z, rec(1,0,8'hD0)}, lv(0,0,0,1), 4'hF); // rr 0->1
    add("pp_pop",      4'b0000, 8'h00, 32'h0, 1'b1, {Z, Z, Z, rec(2,0,8'hD1)}, lv(0,0,0,0), 4'hF); // rr 1->2
    add("c3_push",     4'b0111, 8'b00_11_11_11, 32'h00E2_E1E0, 1'b0, '0, lv(0,1,1,1), 4'hF);
    add("c3_rr2",      4'b0000, 8'h00, 32'h0, 1'b1, {Z, rec(3,2,8'hE2), Z, Z}, lv(0,0,1,1), 4'hF); // rr 2->3
    add("c3_rr3",      4'b0000, 8'h00, 32'h0, 1'b1, {Z, Z, Z, rec(3,0,8'hE0)}, lv(0,0,1,0), 4'hF); // rr 3->0
    add("c3_rr0",      4'b0000, 8'h00, 32'h0, 1'b1, {Z, Z, rec(3,1,8'hE1), Z}, lv(0,0,0,0), 4'hF); // rr 0->1
    add("fp_fill_a",   4'b0010, 8'h00, 32'h0000_5000, 1'b0, '0, lv(0,0,1,0), 4'hF);
    add("fp_fill_b",   4'b0010, 8'h00, 32'h0000_5100, 1'b0, '0, lv(0,0,2,0), 4'hF);
    add("fp_fill_c",   4'b0010, 8'h00, 32'h0000_5200, 1'b0, '0, lv(0,0,3,0), 4'hF);
    add("fp_fill_d",   4'b0010, 8'h00, 32'h0000_5300, 1'b0, '0, lv(0,0,4,0), 4'b1101);
    add("fp_push_pop", 4'b0010, 8'h00, 32'h0000_5400, 1'b1, {Z, Z, rec(0,1,8'h50), Z}, lv(0,0,3,0), 4'hF); // rr 1->2
    add("fp_51",       4'b0000, 8'h00, 32'h0, 1'b1, {Z, Z, rec(0,1,8'h51), Z}, lv(0,0,2,0), 4'hF); // rr 2->3
    add("fp_52",       4'b0000, 8'h00, 32'h0, 1'b1, {Z, Z, rec(0,1,8'h52), Z}, lv(0,0,1,0), 4'hF); // rr 3->0
    add("fp_53",       4'b0000, 8'h00, 32'h0, 1'b1, {Z, Z, rec(0,1,8'h53), Z}, lv(0,0,0,0), 4'hF); // rr 0->1
    add("fp_no_54",    4'b0000, 8'h00, 32'h0, 1'b1, '0, lv(0,0,0,0), 4'hF);
    add("mix_push",    4'b1111, 8'b01_10_01_01, 32'hF3F2_F1F0, 1'b0, '0, lv(1,1,1,1), 4'hF);
    add("mix_rr1",     4'b0000, 8'h00, 32'h0, 1'b1, {Z, rec(2,2,8'hF2), rec(1,1,8'hF1), Z}, lv(1,0,0,1), 4'hF); // rr 1->2
    add("mix_rr2",     4'b0000, 8'h00, 32'h0, 1'b1, {rec(1,3,8'hF3), Z, Z, Z}, lv(0,0,0,1), 4'hF); // rr 2->3
    add("mix_rr3",     4'b0000, 8'h00, 32'h0, 1'b1, {Z, Z, Z, rec(1,0,8'hF0)}, lv(0,0,0,0), 4'hF); // rr 3->0

    // Power-on reset.
    step();
    step();
    chk("por_out", 64'(bus.port_out), 64'h0);
    chk("por_lvl", 64'(bus.fifo_level), 64'h0);
    chk("por_rdy", 64'(bus.in_ready), 64'h0);
    rst = 1'b0;
    #1;
    chk("por_rel_rdy", 64'(bus.in_ready), 64'hF);

    foreach (tv[i]) begin
      drive(tv[i].vld, tv[i].dst, tv[i].dat, tv[i].iss);
      step();
      chk($sformatf("v%0d_%s_out", i, tv[i].nm), 64'(bus.port_out), 64'(tv[i].eout));
      chk($sformatf("v%0d_%s_lvl", i, tv[i].nm), 64'(bus.fifo_level), 64'(tv[i].elvl));
      chk($sformatf("v%0d_%s_rdy", i, tv[i].nm), 64'(bus.in_ready), 64'(tv[i].erdy));
    end

    // Asynchronous reset in the middle of a cycle with FIFOs partly full.
    drive(4'b1001, 8'b11_00_00_00, 32'hBB00_00AA, 1'b0);
    step();
    drive(4'b0001, 8'b00_00_00_00, 32'h0000_00CC, 1'b1);
    step();
    chk("mr_pre_out", 64'(bus.port_out), 64'({rec(3,3,8'hBB), Z, Z, rec(0,0,8'hAA)}));
    chk("mr_pre_lvl", 64'(bus.fifo_level), 64'(lv(0,0,0,1)));
    drive(4'b0000, 8'h00, 32'h0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("mr_out", 64'(bus.port_out), 64'h0);
    chk("mr_lvl", 64'(bus.fifo_level), 64'h0);
    chk("mr_rdy", 64'(bus.in_ready), 64'h0);
    step();
    #2;
    rst = 1'b0;
    #1;
    chk("mr_rel_rdy", 64'(bus.in_ready), 64'hF);
    drive(4'b0000, 8'h00, 32'h0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("mr_post%0d_out", c), 64'(bus.port_out), 64'h0);
      chk($sformatf("mr_post%0d_lvl", c), 64'(bus.fifo_level), 64'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sort_ingress.md
# sort_ingress

Ingress stage of the shared-cache switch, sitting directly upstream of the odd-even merge sort network. It buffers per-port write requests in small FIFOs and forms, once per issue cycle, one record per port in the sort-record format the sorter consumes: valid, destination, source, data. Within each issue cycle it guarantees that no two valid records target the same destination, resolving collisions with a rotating priority pointer.

## Interface
Derived widths:
- PID_W = $clog2(`PORT_NUB_TOTAL)
- REC_W = 1 + 2*PID_W + DATA_WIDTH
- LVL_W = $clog2(FIFO_DEPTH+1)

Parameters:
- PORT_NUB, 4 — ports handled by this instance; power of 2, ≥ 2.
- DATA_WIDTH, `DATA_WIDTH — payload width.
- FIFO_DEPTH, 4 — entries per port FIFO; power of 2, ≥ 2.
- PORT_BASE, 0 — global port id of local port 0.

Ports:
- clk  in  1  — single clock, rising edge.
- rst  in  1  — asynchronous, active-high reset.
- in_valid  in  PORT_NUB  — per-port push request.
- in_ready  out  PORT_NUB  — per-port FIFO can accept.
- in_dst  in  PORT_NUB*PID_W  — destination of port k at [(k+1)*PID_W-1 : k*PID_W].
- in_data  in  PORT_NUB*DATA_WIDTH  — payload of port k, same slicing.
- issue_en  in  1  — issue one record vector this cycle.
- port_out  out  PORT_NUB*REC_W  — sorter input; slot k at [(k+1)*REC_W-1 : k*REC_W].
- fifo_level  out  PORT_NUB*LVL_W  — occupancy of each FIFO, 0..FIFO_DEPTH.

## Operation
- Record layout, MSB to LSB: {valid, dst[PID_W], src[PID_W], data[DATA_WIDTH]}.
  - Invalid slots are all-zero.
  - src = PORT_BASE + k, truncated to PID_W.
- Push:
  - in_ready[k] = (level[k] < FIFO_DEPTH) and not rst. It depends only on level, never on a same-cycle pop, so a full FIFO refuses input even while popping.
  - On in_valid[k] & in_ready[k], {dst, data} is written at the tail.
- Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. A push and a pop in the same cycle leave level unchanged.
- Issue happens on a cycle with issue_en = 1:
  - Candidates are ports with level ≥ 1 at the start of the cycle. A push into an empty FIFO is not eligible until the next cycle.
  - Scan order is rr_ptr, rr_ptr+1, …, modulo PORT_NUB.
  - A candidate is granted unless a port earlier in the scan was already granted the same dst.
  - Each granted port pops its head; slot k is registered as {1, dst, src, data}.
  - Non-granted slots register as zero.
  - rr_ptr advances by 1 (mod PORT_NUB) if at least one grant occurred; otherwise it holds.
- On a cycle with issue_en = 0:
  - port_out registers all-zero (a bubble).
  - No pops; rr_ptr holds.
  - Pushes still proceed.
- State per port: FIFO storage, wr_ptr, rd_ptr, level. Global state: rr_ptr (log2 PORT_NUB bits), port_out register.

## Timing
- Reset (asynchronous, immediate):
  - port_out = 0, fifo_level = 0, rr_ptr = 0, all pointers = 0.
  - in_ready = 0 while rst is high, and becomes 1 combinationally after release.
  - FIFO contents are discarded; no pre-reset data ever appears on port_out.
- Latency: an entry accepted at edge E appears on port_out after edge E+1 at the earliest, given issue_en = 1 at E+1 and the port is granted.
- port_out is fully registered and holds for exactly one cycle per issue decision. There is no handshake toward the sorter; the sorter accepts a vector every cycle.
- fifo_level and in_ready reflect state after the most recent edge.
- At most one pop per port per cycle; at most one valid record per destination per vector.

## Test plan
Configuration for all scenarios: PORT_NUB=4, `PORT_NUB_TOTAL=4, DATA_WIDTH=8, FIFO_DEPTH=4, PORT_BASE=0.

1. Reset: assert rst mid-run with FIFOs partly full → immediately port_out=0, fifo_level=0, in_ready=0000. Release and wait 3 issue cycles → in_ready=1111, only zero vectors issued.
2. Single push: port2 dst=1 data=0xA5, then issue_en=1 → next cycle slot2 = {1,01,10,A5}, slots 0/1/3 = 0, level[2]=0, rr_ptr=1.
3. Collision: rr_ptr=0, port0 and port3 both dst=2 (data 0x11/0x33), issue → slot0 valid with 0x11, slot3 zero. Next issue (rr_ptr=1, scan order 1,2,3,0) → slot3 = {1,10,11,33}.
4. Full: issue_en=0, push 4 entries to port1 → level[1]=4, in_ready[1]=0. A 5th in_valid is not accepted. Issue once → level[1]=3, in_ready[1]=1.
5. Parallel distinct: ports 0–3 push dst 3,2,1,0 in the same cycle, issue next cycle → all four slots valid with matching src, all levels 0.
6. Bubble: data queued, issue_en=0 for 3 cycles → port_out=0 each cycle, levels and rr_ptr unchanged.
